// File: rtl/mac_row_dual.sv
// mac_row_dual: row of `col` MAC PEs with per-instruction weight-stationary (WS) or
// output-stationary (OS) dataflow. Activations and instructions ripple west-to-east one
// column per cycle; psums (WS) or weights (OS) enter each column from the north.
// Build option: define MAC_ROW_SAT_EN to saturate psum additions and OS accumulation
// instead of wrapping.
module mac_row_dual #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [bw-1:0]          in_w,
    input  logic [3:0]             inst_w,
    input  logic [psum_bw*col-1:0] in_n,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid,
    output logic [bw-1:0]          out_e,
    output logic [3:0]             inst_e
);

    // unsigned bw activation times signed bw weight fits in 2*bw+1 signed bits
    localparam int unsigned PW = 2 * bw + 1;

    logic [col-1:0][bw-1:0] a_bus;
    logic [col-1:0][3:0]    inst_bus;

    // psum_bw-wide add; optionally clamps on signed overflow
    function automatic logic [psum_bw-1:0] add_psum(input logic [psum_bw-1:0] x,
                                                    input logic [psum_bw-1:0] y);
        logic [psum_bw-1:0] s;
        s = x + y;
`ifdef MAC_ROW_SAT_EN
        if ((x[psum_bw-1] == y[psum_bw-1]) && (s[psum_bw-1] != x[psum_bw-1])) begin
            s = {x[psum_bw-1], {(psum_bw-1){~x[psum_bw-1]}}};
        end
`endif
        return s;
    endfunction

    for (genvar j = 0; j < col; j++) begin : gen_pe
        logic [bw-1:0]      a_in, a_q;
        logic [3:0]         i_in, inst_q, inst_d;
        logic [bw-1:0]      w_q, w_d, w_mul;
        logic               loaded_q, loaded_d;
        logic [psum_bw-1:0] acc_q, acc_d, out_q, out_d, n_in, prod_ext;
        logic               valid_q, valid_d;
        logic [PW-1:0]      prod;
        logic               ld, ex, dr, os;

        if (j == 0) begin : gen_src
            assign a_in = in_w;
            assign i_in = inst_w;
        end else begin : gen_chain
            assign a_in = a_bus[j-1];
            assign i_in = inst_bus[j-1];
        end

        assign n_in = in_n[psum_bw*j +: psum_bw];
        assign ld   = i_in[0];
        assign ex   = i_in[1];
        assign dr   = i_in[2];
        assign os   = i_in[3];

        // OS takes its weight from the north; WS uses the stored one
        assign w_mul    = os ? n_in[bw-1:0] : w_q;
        // zero-extended activation times sign-extended weight, truncated to PW bits
        assign prod     = {{(bw + 1){1'b0}}, a_in} * {{(bw + 1){w_mul[bw-1]}}, w_mul};
        assign prod_ext = {{(psum_bw - PW){prod[PW-1]}}, prod};

        // Next state: drain > execute > load; load token is consumed by the first unloaded PE
        always_comb begin
            w_d      = w_q;
            loaded_d = loaded_q;
            acc_d    = acc_q;
            out_d    = out_q;
            valid_d  = 1'b0;
            inst_d   = {i_in[3:1], ld & loaded_q & ~os};
            if (!os) begin
                if (dr) begin
                    w_d      = '0;
                    loaded_d = 1'b0;
                end else if (ex) begin
                    out_d   = add_psum(n_in, prod_ext);
                    valid_d = 1'b1;
                end else if (ld && !loaded_q) begin
                    w_d      = a_in;
                    loaded_d = 1'b1;
                end
            end else begin
                if (dr) begin
                    out_d   = acc_q;
                    acc_d   = '0;
                    valid_d = 1'b1;
                end else if (ex) begin
                    acc_d = add_psum(acc_q, prod_ext);
                    out_d = n_in;
                end
            end
        end

        // PE state registers
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_q      <= '0;
                inst_q   <= '0;
                w_q      <= '0;
                loaded_q <= 1'b0;
                acc_q    <= '0;
                out_q    <= '0;
                valid_q  <= 1'b0;
            end else begin
                a_q      <= a_in;
                inst_q   <= inst_d;
                w_q      <= w_d;
                loaded_q <= loaded_d;
                acc_q    <= acc_d;
                out_q    <= out_d;
                valid_q  <= valid_d;
            end
        end

        assign a_bus[j]                      = a_q;
        assign inst_bus[j]                   = inst_q;
        assign out_s[psum_bw*j +: psum_bw]   = out_q;
        assign valid[j]                      = valid_q;
    end

    assign out_e  = a_bus[col-1];
    assign inst_e = inst_bus[col-1];

endmodule

// File: tb/tb_mac_row_dual.sv
// Self-checking bench for mac_row_dual: directed scenarios plus random instructions, all
// compared every cycle against a cycle-indexed behavioural model of the row.
module tb_mac_row_dual;

    localparam int BW   = 4;
    localparam int PBW  = 16;
    localparam int COL  = 8;
    localparam int HMAX = 2048;

    localparam logic [3:0] I_LOAD  = 4'b0001;
    localparam logic [3:0] I_EXEC  = 4'b0010;
    localparam logic [3:0] I_DRAIN = 4'b0100;
    localparam logic [3:0] I_OS    = 4'b1000;

    logic               clk;
    logic               reset;
    logic [BW-1:0]      in_w;
    logic [3:0]         inst_w;
    logic [PBW*COL-1:0] in_n;
    logic [PBW*COL-1:0] out_s;
    logic [COL-1:0]     valid;
    logic [BW-1:0]      out_e;
    logic [3:0]         inst_e;

    mac_row_dual #(.bw(BW), .psum_bw(PBW), .col(COL)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_w   (in_w),
        .inst_w (inst_w),
        .in_n   (in_n),
        .out_s  (out_s),
        .valid  (valid),
        .out_e  (out_e),
        .inst_e (inst_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Model: per-column architectural state plus a history of what entered column 0.
    // Entry s reaches column j at edge s+j; live[s] says whether its load bit survives.
    int            m_w[COL];
    bit            m_ld[COL];
    int            m_acc[COL];
    int            m_out[COL];
    bit            m_val[COL];
    logic [BW-1:0] h_a[HMAX];
    logic [3:0]    h_i[HMAX];
    bit            live[HMAX];
    int            t;
    int            vcnt[COL];

    function automatic int sw(input logic [BW-1:0] v);
        logic signed [BW-1:0] x;
        x = v;
        return int'(x);
    endfunction

    function automatic int s16(input logic [PBW-1:0] v);
        logic signed [PBW-1:0] x;
        x = v;
        return int'(x);
    endfunction

    function automatic int psum_add(input int x, input int y);
        int s;
        s = x + y;
`ifdef MAC_ROW_SAT_EN
        if (s > (1 << (PBW - 1)) - 1) return (1 << (PBW - 1)) - 1;
        if (s < -(1 << (PBW - 1))) return -(1 << (PBW - 1));
        return s;
`else
        return s16(s[PBW-1:0]);
`endif
    endfunction

    task automatic model_reset();
        for (int j = 0; j < COL; j++) begin
            m_w[j] = 0; m_ld[j] = 0; m_acc[j] = 0; m_out[j] = 0; m_val[j] = 0;
        end
        t = 0;
    endtask

    task automatic model_edge();
        h_a[t]  = in_w;
        h_i[t]  = inst_w;
        live[t] = inst_w[0];
        for (int j = 0; j < COL; j++) begin
            int            s;
            int            a;
            logic [3:0]    ins;
            bit            ld;
            bit            was;
            logic [PBW-1:0] nv;
            s = t - j;
            if (s >= 0) begin
                a = int'(h_a[s]); ins = h_i[s]; ld = live[s];
            end else begin
                a = 0; ins = 4'b0; ld = 0;
            end
            nv  = in_n[PBW*j +: PBW];
            was = m_ld[j];
            m_val[j] = 0;
            if (!ins[3]) begin
                if (ins[2]) begin
                    m_w[j] = 0; m_ld[j] = 0;
                end else if (ins[1]) begin
                    m_out[j] = psum_add(s16(nv), a * m_w[j]);
                    m_val[j] = 1;
                end else if (ld && !was) begin
                    m_w[j] = sw(h_a[s]); m_ld[j] = 1;
                end
            end else begin
                if (ins[2]) begin
                    m_out[j] = m_acc[j]; m_acc[j] = 0; m_val[j] = 1;
                end else if (ins[1]) begin
                    m_acc[j] = psum_add(m_acc[j], a * sw(nv[BW-1:0]));
                    m_out[j] = s16(nv);
                end
            end
            if (s >= 0) live[s] = ld && was && !ins[3];
        end
        t++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [PBW*COL-1:0] es;
        logic [COL-1:0]     ev;
        logic [BW-1:0]      ee;
        logic [3:0]         eie;
        int                 s;
        for (int j = 0; j < COL; j++) begin
            int v;
            v = m_out[j];
            es[PBW*j +: PBW] = v[PBW-1:0];
            ev[j] = m_val[j];
        end
        s = t - COL;
        if (s >= 0) begin
            ee  = h_a[s];
            eie = {h_i[s][3:1], live[s]};
        end else begin
            ee  = '0;
            eie = '0;
        end
        chk("model_out_s", 128'(out_s), 128'(es));
        chk("model_valid", 128'(valid), 128'(ev));
        chk("model_out_e", 128'(out_e), 128'(ee));
        chk("model_inst_e", 128'(inst_e), 128'(eie));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int j = 0; j < COL; j++) vcnt[j] += int'(valid[j]);
        check_all();
    endtask

    task automatic op(input logic [BW-1:0] a, input logic [3:0] inst, input int n);
        in_w   = a;
        inst_w = inst;
        repeat (n) tick();
        in_w   = '0;
        inst_w = '0;
    endtask

    task automatic set_n_all(input logic [PBW-1:0] v);
        for (int j = 0; j < COL; j++) in_n[PBW*j +: PBW] = v;
    endtask

    task automatic clr_vcnt();
        for (int j = 0; j < COL; j++) vcnt[j] = 0;
    endtask

    task automatic ws_load_all(input logic [BW-1:0] w);
        op('0, I_DRAIN, 1);
        op('0, 4'b0, COL);
        op(w, I_LOAD, COL);
        op('0, 4'b0, COL);
    endtask

    task automatic check_cols(input string tag, input logic [PBW-1:0] exp);
        for (int j = 0; j < COL; j++) chk(tag, 128'(out_s[PBW*j +: PBW]), 128'(exp));
    endtask

    logic [PBW-1:0] rn[COL];
    logic [PBW-1:0] sat_exp;

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b0;
        in_w   = '0;
        inst_w = '0;
        in_n   = '0;
        model_reset();
        clr_vcnt();

        // Reset state
        #2;
        chk("rst_out_s", 128'(out_s), 128'(0));
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_out_e", 128'(out_e), 128'(0));
        chk("rst_inst_e", 128'(inst_e), 128'(0));
        #1 reset = 1'b1;

        // WS flow: weight k-4 into PE k, then a=3 with in_n=0
        for (int k = 0; k < COL; k++) op(BW'(k - 4), I_LOAD, 1);
        op('0, 4'b0, COL);
        op(4'd3, I_EXEC, 1);
        chk("ws_valid_pulse", 128'(valid), 128'(1));
        for (int j = 1; j < COL; j++) begin
            op('0, 4'b0, 1);
            chk("ws_valid_pulse", 128'(valid), 128'(1) << j);
        end
        op('0, 4'b0, 1);
        for (int j = 0; j < COL; j++) begin
            logic [PBW-1:0] e;
            e = PBW'(3 * (j - 4));
            chk("ws_flow", 128'(out_s[PBW*j +: PBW]), 128'(e));
        end

        // Signed edge: weight -8 times activation 15
        ws_load_all(4'h8);
        op(4'd15, I_EXEC, 1);
        op('0, 4'b0, COL);
        check_cols("ws_signed_edge", 16'hFF88);

        // Saturation boundary
        ws_load_all(4'd7);
        set_n_all(16'h7FF0);
`ifdef MAC_ROW_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'h8059;
`endif
        op(4'd15, I_EXEC, 1);
        op('0, 4'b0, COL);
        check_cols("ws_saturation", sat_exp);
        set_n_all('0);

        // Reload: drain alone raises no valid, then weight 1 and a=5
        clr_vcnt();
        op('0, I_DRAIN, 1);
        op('0, 4'b0, COL);
        for (int j = 0; j < COL; j++) chk("drain_no_valid", 128'(vcnt[j]), 128'(0));
        op(4'd1, I_LOAD, COL);
        op('0, 4'b0, COL);
        op(4'd5, I_EXEC, 1);
        op('0, 4'b0, COL);
        check_cols("ws_reload", 16'd5);

        // OS flow: 4 executes of 2*3, then drain, then a second drain
        set_n_all(16'd3);
        clr_vcnt();
        op(4'd2, I_OS | I_EXEC, 1);
        chk("os_echo", 128'(out_s[PBW-1:0]), 128'(3));
        op(4'd2, I_OS | I_EXEC, 3);
        op(4'd2, I_OS | I_DRAIN, 1);
        op('0, 4'b0, COL);
        check_cols("os_drain", 16'd24);
        for (int j = 0; j < COL; j++) chk("os_valid_count", 128'(vcnt[j]), 128'(1));
        clr_vcnt();
        op('0, I_OS | I_DRAIN, 1);
        op('0, 4'b0, COL);
        check_cols("os_drain2", 16'd0);
        for (int j = 0; j < COL; j++) chk("os_valid_count2", 128'(vcnt[j]), 128'(1));

        // Random instructions, activations and north inputs
        for (int i = 0; i < 300; i++) begin
            in_w   = BW'($urandom);
            inst_w = 4'($urandom);
            for (int j = 0; j < COL; j++) in_n[PBW*j +: PBW] = PBW'($urandom);
            tick();
        end

        // Asynchronous reset in the middle of execution
        ws_load_all(4'd1);
        set_n_all(16'd100);
        op(4'd9, I_EXEC, 3);
        in_w   = 4'd9;
        inst_w = I_EXEC;
        reset  = 1'b0;
        #1;
        chk("async_rst_out_s", 128'(out_s), 128'(0));
        chk("async_rst_valid", 128'(valid), 128'(0));
        chk("async_rst_out_e", 128'(out_e), 128'(0));
        chk("async_rst_inst_e", 128'(inst_e), 128'(0));
        reset  = 1'b1;
        inst_w = '0;
        in_w   = '0;
        model_reset();
        for (int j = 0; j < COL; j++) begin
            rn[j] = PBW'($urandom);
            in_n[PBW*j +: PBW] = rn[j];
        end
        op(4'($urandom_range(1, 15)), I_EXEC, 1);
        op('0, 4'b0, COL);
        for (int j = 0; j < COL; j++) chk("post_rst_passthru", 128'(out_s[PBW*j +: PBW]),
                                           128'(rn[j]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
